// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARM pipeline control logic.
package arm_pipe_pkg;

    localparam int unsigned REG_IDX_W = 4;
    localparam int unsigned WCNT_W    = 4;

    typedef enum logic [0:0] {
        IDLE,
        WAIT
    } mem_state_t;

    // True when a source register matches a destination that will be written back.
    function automatic logic reg_hit(
        input logic [REG_IDX_W-1:0] src,
        input logic [REG_IDX_W-1:0] dest,
        input logic                 dest_valid
    );
        return dest_valid && (src == dest);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Pipeline-side bundle of the freeze/flush controller: hazard inputs in, stage controls out.
interface pipeline_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    import arm_pipe_pkg::*;

    logic [REG_IDX_W-1:0] id_src1;
    logic [REG_IDX_W-1:0] id_src2;
    logic                 id_use_src1;
    logic                 id_use_src2;
    logic [REG_IDX_W-1:0] exe_dest;
    logic                 exe_wb_en;
    logic                 exe_mem_r;
    logic [REG_IDX_W-1:0] mem_dest;
    logic                 mem_wb_en;
    logic                 mem_req;
    logic                 branch_taken;

    logic                 freeze_if;
    logic                 freeze_id;
    logic                 freeze_back;
    logic                 flush_if_reg;
    logic                 flush_id_reg;
    logic                 mem_busy;
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     flush_cnt;

    // Pipeline datapath side.
    modport master (
        output id_src1, id_src2, id_use_src1, id_use_src2,
        output exe_dest, exe_wb_en, exe_mem_r, mem_dest, mem_wb_en, mem_req, branch_taken,
        input  freeze_if, freeze_id, freeze_back, flush_if_reg, flush_id_reg, mem_busy,
        input  stall_cnt, flush_cnt
    );

    // Controller side.
    modport slave (
        input  id_src1, id_src2, id_use_src1, id_use_src2,
        input  exe_dest, exe_wb_en, exe_mem_r, mem_dest, mem_wb_en, mem_req, branch_taken,
        output freeze_if, freeze_id, freeze_back, flush_if_reg, flush_id_reg, mem_busy,
        output stall_cnt, flush_cnt
    );

endinterface

// File: rtl/mem_wait_fsm.sv
// Wait-state sequencer for multi-cycle SRAM accesses in the MEM stage.
// An access holds mem_stall for MEM_WAIT-1 cycles, then releases for one cycle.
module mem_wait_fsm
    import arm_pipe_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_req,
    output logic mem_stall,
    output logic mem_busy
);

    localparam bit HasWait = (MEM_WAIT > 1);
    // First WAIT cycle sees MEM_WAIT-2; the cycle with wcnt==0 is the release.
    localparam logic [WCNT_W-1:0] WcntLoad = HasWait ? WCNT_W'(MEM_WAIT - 2) : '0;

    mem_state_t        state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;

    // State and wait counter registers; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            IDLE: begin
                if (mem_req && HasWait) begin
                    state_d = WAIT;
                    wcnt_d  = WcntLoad;
                end
            end
            WAIT: begin
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Outputs; the release cycle (WAIT, wcnt==0) drops the stall so MEM_Reg captures.
    always_comb begin
        mem_stall = 1'b0;
        mem_busy  = 1'b0;
        if (rst) begin
            unique case (state_q)
                IDLE: mem_stall = mem_req && HasWait;
                WAIT: begin
                    mem_stall = (wcnt_q != '0);
                    mem_busy  = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central freeze/flush controller for the 5-stage pipeline: RAW hazard detection,
// MEM wait-state sequencing, branch squash and stall/flush performance counters.
module pipeline_ctrl
    import arm_pipe_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 4,
    parameter bit          FWD_EN   = 1'b0,
    parameter int unsigned CNT_W    = 16
) (
    input logic            clk,
    input logic            rst,
    pipeline_ctrl_if.slave bus
);

    logic mem_stall;
    logic mem_busy;
    logic hit1, hit2, hz;

    logic freeze_if, freeze_id, freeze_back, flush_if_reg, flush_id_reg;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    mem_wait_fsm #(
        .MEM_WAIT (MEM_WAIT)
    ) u_mem_wait_fsm (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (bus.mem_req),
        .mem_stall (mem_stall),
        .mem_busy  (mem_busy)
    );

    // RAW hazard detect; with forwarding only a load in EXE cannot be bypassed.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        if (FWD_EN) begin
            hit1 = bus.id_use_src1
                && reg_hit(bus.id_src1, bus.exe_dest, bus.exe_wb_en && bus.exe_mem_r);
            hit2 = bus.id_use_src2
                && reg_hit(bus.id_src2, bus.exe_dest, bus.exe_wb_en && bus.exe_mem_r);
        end else begin
            hit1 = bus.id_use_src1
                && (reg_hit(bus.id_src1, bus.exe_dest, bus.exe_wb_en)
                    || reg_hit(bus.id_src1, bus.mem_dest, bus.mem_wb_en));
            hit2 = bus.id_use_src2
                && (reg_hit(bus.id_src2, bus.exe_dest, bus.exe_wb_en)
                    || reg_hit(bus.id_src2, bus.mem_dest, bus.mem_wb_en));
        end
    end

    assign hz = hit1 || hit2;

    // Priority mux: memory stall, then taken branch, then hazard bubble.
    always_comb begin
        freeze_if    = 1'b0;
        freeze_id    = 1'b0;
        freeze_back  = 1'b0;
        flush_if_reg = 1'b0;
        flush_id_reg = 1'b0;
        if (!rst) begin
            // everything held low during reset
        end else if (mem_stall) begin
            // A pending branch waits here and is re-evaluated on the release cycle.
            freeze_if   = 1'b1;
            freeze_id   = 1'b1;
            freeze_back = 1'b1;
        end else if (bus.branch_taken) begin
            flush_if_reg = 1'b1;
            flush_id_reg = 1'b1;
        end else if (hz) begin
            freeze_if    = 1'b1;
            freeze_id    = 1'b1;
            flush_id_reg = 1'b1;
        end
    end

    // Saturating counter next-state.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (freeze_if && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_if_reg && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.freeze_if    = freeze_if;
    assign bus.freeze_id    = freeze_id;
    assign bus.freeze_back  = freeze_back;
    assign bus.flush_if_reg = flush_if_reg;
    assign bus.flush_id_reg = flush_id_reg;
    assign bus.mem_busy     = mem_busy;
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: two instances (A: MEM_WAIT=4, no forwarding, 16-bit counters;
// B: MEM_WAIT=1, forwarding, 4-bit counters) against an access-position reference model.
module tb_pipeline_ctrl;

    typedef struct packed {
        logic [3:0] src1;
        logic [3:0] src2;
        logic       use1;
        logic       use2;
        logic [3:0] exe_dest;
        logic       exe_wb;
        logic       exe_mr;
        logic [3:0] mem_dest;
        logic       mem_wb;
        logic       mem_req;
        logic       br;
    } in_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn [2];
    in_t  inp  [2];

    int mw   [2] = '{4, 1};
    bit fwd  [2] = '{1'b0, 1'b1};
    int cmax [2] = '{65535, 15};

    // Model state: pos = cycle index within the current memory access (0 = none).
    int pos [2] = '{0, 0};
    int sc  [2] = '{0, 0};
    int fc  [2] = '{0, 0};

    int n_cmp = 0;
    int n_err = 0;

    pipeline_ctrl_if #(.CNT_W(16)) ia ();
    pipeline_ctrl_if #(.CNT_W(4))  ib ();

    assign ia.id_src1      = inp[0].src1;
    assign ia.id_src2      = inp[0].src2;
    assign ia.id_use_src1  = inp[0].use1;
    assign ia.id_use_src2  = inp[0].use2;
    assign ia.exe_dest     = inp[0].exe_dest;
    assign ia.exe_wb_en    = inp[0].exe_wb;
    assign ia.exe_mem_r    = inp[0].exe_mr;
    assign ia.mem_dest     = inp[0].mem_dest;
    assign ia.mem_wb_en    = inp[0].mem_wb;
    assign ia.mem_req      = inp[0].mem_req;
    assign ia.branch_taken = inp[0].br;

    assign ib.id_src1      = inp[1].src1;
    assign ib.id_src2      = inp[1].src2;
    assign ib.id_use_src1  = inp[1].use1;
    assign ib.id_use_src2  = inp[1].use2;
    assign ib.exe_dest     = inp[1].exe_dest;
    assign ib.exe_wb_en    = inp[1].exe_wb;
    assign ib.exe_mem_r    = inp[1].exe_mr;
    assign ib.mem_dest     = inp[1].mem_dest;
    assign ib.mem_wb_en    = inp[1].mem_wb;
    assign ib.mem_req      = inp[1].mem_req;
    assign ib.branch_taken = inp[1].br;

    pipeline_ctrl #(.MEM_WAIT(4), .FWD_EN(1'b0), .CNT_W(16)) dut_a (
        .clk (clk),
        .rst (rstn[0]),
        .bus (ia)
    );

    pipeline_ctrl #(.MEM_WAIT(1), .FWD_EN(1'b1), .CNT_W(4)) dut_b (
        .clk (clk),
        .rst (rstn[1]),
        .bus (ib)
    );

    // ---------------- reference model ----------------
    function automatic int cur_pos(int d);
        if (pos[d] != 0) return pos[d] + 1;
        return inp[d].mem_req ? 1 : 0;
    endfunction

    // Does the ID instruction read register r before its producer has written it?
    function automatic bit reads_pending(int d, logic [3:0] r, logic u);
        if (!u) return 1'b0;
        if (fwd[d]) return inp[d].exe_wb && inp[d].exe_mr && (r == inp[d].exe_dest);
        return (inp[d].exe_wb && (r == inp[d].exe_dest)) || (inp[d].mem_wb && (r == inp[d].mem_dest));
    endfunction

    // {freeze_if, freeze_id, freeze_back, flush_if_reg, flush_id_reg, mem_busy}
    function automatic logic [5:0] exp_out(int d);
        int p;
        bit stall, busy, hz;
        p     = cur_pos(d);
        stall = (p != 0) && (p < mw[d]);
        busy  = (p >= 2);
        hz    = reads_pending(d, inp[d].src1, inp[d].use1)
             || reads_pending(d, inp[d].src2, inp[d].use2);
        if (!rstn[d]) return 6'b000000;
        if (stall)    return {5'b11100, busy};
        if (inp[d].br) return {5'b00011, busy};
        if (hz)       return {5'b11001, busy};
        return {5'b00000, busy};
    endfunction

    function automatic bit exp_bit(int d, int k);
        logic [5:0] v;
        v = exp_out(d);
        return v[k];
    endfunction

    function automatic logic [5:0] act_out(int d);
        if (d == 0) return {ia.freeze_if, ia.freeze_id, ia.freeze_back,
                            ia.flush_if_reg, ia.flush_id_reg, ia.mem_busy};
        return {ib.freeze_if, ib.freeze_id, ib.freeze_back,
                ib.flush_if_reg, ib.flush_id_reg, ib.mem_busy};
    endfunction

    function automatic int act_sc(int d);
        return (d == 0) ? int'(ia.stall_cnt) : int'(ib.stall_cnt);
    endfunction

    function automatic int act_fc(int d);
        return (d == 0) ? int'(ia.flush_cnt) : int'(ib.flush_cnt);
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rstn[d]) begin
                pos[d] <= 0;
                sc[d]  <= 0;
                fc[d]  <= 0;
            end else begin
                pos[d] <= (cur_pos(d) == mw[d]) ? 0 : cur_pos(d);
                if (exp_bit(d, 5) && sc[d] < cmax[d]) sc[d] <= sc[d] + 1;
                if (exp_bit(d, 2) && fc[d] < cmax[d]) fc[d] <= fc[d] + 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] rnd_reg();
        return ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(13, 15));
    endfunction

    function automatic in_t rnd_in();
        in_t x;
        x.src1     = rnd_reg();
        x.src2     = rnd_reg();
        x.use1     = 1'($urandom_range(0, 1));
        x.use2     = 1'($urandom_range(0, 1));
        x.exe_dest = rnd_reg();
        x.exe_wb   = 1'($urandom_range(0, 1));
        x.exe_mr   = 1'($urandom_range(0, 1));
        x.mem_dest = rnd_reg();
        x.mem_wb   = 1'($urandom_range(0, 1));
        x.mem_req  = ($urandom_range(0, 3) == 0);
        x.br       = ($urandom_range(0, 5) == 0);
        return x;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rstn[0] = 1'b0;
        rstn[1] = 1'b0;
        inp[0]  = '1;
        inp[1]  = '1;
        tick();
        tick();
        #4;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (act_out(d) !== 6'b000000) begin
                n_err++;
                $display("FAIL reset_out[%0d]: got %b want 000000", d, act_out(d));
            end
            n_cmp++;
            if (act_sc(d) !== 0 || act_fc(d) !== 0) begin
                n_err++;
                $display("FAIL reset_cnt[%0d]: got stall=%0d flush=%0d want 0/0", d, act_sc(d), act_fc(d));
            end
        end
        inp[0]  = '0;
        inp[1]  = '0;
        rstn[0] = 1'b1;
        rstn[1] = 1'b1;
        tick();
    endtask

    task automatic test_mem_wait();
        inp[0] = '0;
        inp[0].mem_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #4;
            n_cmp++;
            if (ia.freeze_back !== (k < 3) || ia.mem_busy !== (k >= 1)) begin
                n_err++;
                $display("FAIL mem_wait cyc%0d: got stall=%b busy=%b want %b/%b",
                         k, ia.freeze_back, ia.mem_busy, (k < 3), (k >= 1));
            end
            tick();
        end
        inp[0].mem_req = 1'b0;
        #4;
        n_cmp++;
        if (ia.stall_cnt !== 16'd3 || ia.mem_busy !== 1'b0) begin
            n_err++;
            $display("FAIL mem_wait_cnt: got stall_cnt=%0d busy=%b want 3/0", ia.stall_cnt, ia.mem_busy);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        inp[0] = '0;
        inp[0].mem_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #4;
            n_cmp++;
            if (ia.freeze_if !== ((k % 4) != 3) || ia.mem_busy !== ((k % 4) != 0)) begin
                n_err++;
                $display("FAIL back_to_back cyc%0d: got freeze_if=%b busy=%b want %b/%b",
                         k, ia.freeze_if, ia.mem_busy, ((k % 4) != 3), ((k % 4) != 0));
            end
            tick();
        end
        inp[0].mem_req = 1'b0;
        #4;
        n_cmp++;
        if (ia.stall_cnt !== 16'd9) begin
            n_err++;
            $display("FAIL back_to_back_cnt: got %0d want 9", ia.stall_cnt);
        end
        tick();
    endtask

    task automatic test_hazard();
        // A, no forwarding: EXE hit on src1 (R3), MEM hit on src2 (R0), unused src (R15).
        inp[0] = '0;
        inp[0].src1 = 4'd3; inp[0].use1 = 1'b1; inp[0].exe_dest = 4'd3; inp[0].exe_wb = 1'b1;
        #4;
        n_cmp++;
        if (act_out(0) !== 6'b110010) begin
            n_err++;
            $display("FAIL hazard_exe: got %b want 110010", act_out(0));
        end
        tick();
        inp[0] = '0;
        inp[0].src2 = 4'd0; inp[0].use2 = 1'b1; inp[0].mem_dest = 4'd0; inp[0].mem_wb = 1'b1;
        #4;
        n_cmp++;
        if (act_out(0) !== 6'b110010) begin
            n_err++;
            $display("FAIL hazard_mem_r0: got %b want 110010", act_out(0));
        end
        tick();
        inp[0] = '0;
        inp[0].src1 = 4'd15; inp[0].exe_dest = 4'd15; inp[0].exe_wb = 1'b1;
        #4;
        n_cmp++;
        if (act_out(0) !== 6'b000000) begin
            n_err++;
            $display("FAIL hazard_unused: got %b want 000000", act_out(0));
        end
        tick();
        inp[0] = '0;
        #4;
        n_cmp++;
        if (ia.stall_cnt !== 16'd11) begin
            n_err++;
            $display("FAIL hazard_cnt: got %0d want 11", ia.stall_cnt);
        end
        tick();
        // B, forwarding: only a load in EXE stalls.
        inp[1] = '0;
        inp[1].src1 = 4'd3; inp[1].use1 = 1'b1; inp[1].exe_dest = 4'd3; inp[1].exe_wb = 1'b1;
        #4;
        n_cmp++;
        if (act_out(1) !== 6'b000000) begin
            n_err++;
            $display("FAIL fwd_alu: got %b want 000000", act_out(1));
        end
        tick();
        inp[1].exe_mr = 1'b1;
        #4;
        n_cmp++;
        if (act_out(1) !== 6'b110010) begin
            n_err++;
            $display("FAIL fwd_load_use: got %b want 110010", act_out(1));
        end
        tick();
        inp[1] = '0;
        inp[1].src2 = 4'd9; inp[1].use2 = 1'b1; inp[1].mem_dest = 4'd9; inp[1].mem_wb = 1'b1;
        #4;
        n_cmp++;
        if (act_out(1) !== 6'b000000) begin
            n_err++;
            $display("FAIL fwd_mem: got %b want 000000", act_out(1));
        end
        tick();
        inp[1] = '0;
        #4;
        n_cmp++;
        if (ib.stall_cnt !== 4'd1) begin
            n_err++;
            $display("FAIL fwd_cnt: got %0d want 1", ib.stall_cnt);
        end
        tick();
    endtask

    task automatic test_branch_over_hazard();
        inp[0] = '0;
        inp[0].src1 = 4'd7; inp[0].use1 = 1'b1; inp[0].exe_dest = 4'd7; inp[0].exe_wb = 1'b1;
        inp[0].br = 1'b1;
        #4;
        n_cmp++;
        if (act_out(0) !== 6'b000110 || ia.flush_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL branch_hz: got %b flush_cnt=%0d want 000110/0", act_out(0), ia.flush_cnt);
        end
        tick();
        inp[0] = '0;
        #4;
        n_cmp++;
        if (ia.flush_cnt !== 16'd1 || ia.stall_cnt !== 16'd11) begin
            n_err++;
            $display("FAIL branch_hz_cnt: got flush=%0d stall=%0d want 1/11", ia.flush_cnt, ia.stall_cnt);
        end
        tick();
    endtask

    task automatic test_branch_in_wait();
        logic [5:0] want;
        inp[0] = '0;
        inp[0].mem_req = 1'b1;
        inp[0].br = 1'b1;
        for (int k = 0; k < 4; k++) begin
            want = (k < 3) ? {5'b11100, 1'(k >= 1)} : 6'b000111;
            #4;
            n_cmp++;
            if (act_out(0) !== want || ia.flush_cnt !== 16'd1) begin
                n_err++;
                $display("FAIL branch_wait cyc%0d: got %b flush_cnt=%0d want %b/1",
                         k, act_out(0), ia.flush_cnt, want);
            end
            tick();
        end
        inp[0] = '0;
        #4;
        n_cmp++;
        if (ia.flush_cnt !== 16'd2 || ia.stall_cnt !== 16'd14) begin
            n_err++;
            $display("FAIL branch_wait_cnt: got flush=%0d stall=%0d want 2/14", ia.flush_cnt, ia.stall_cnt);
        end
        tick();
    endtask

    task automatic test_reset_in_wait();
        inp[0] = '0;
        inp[0].mem_req = 1'b1;
        tick();
        tick();
        rstn[0] = 1'b0;   // third access cycle: wait counter is 1
        #4;
        n_cmp++;
        if (act_out(0) !== 6'b000000) begin
            n_err++;
            $display("FAIL rst_wait_out: got %b want 000000", act_out(0));
        end
        tick();
        rstn[0] = 1'b1;
        inp[0] = '0;
        #4;
        n_cmp++;
        if (act_out(0) !== 6'b000000 || ia.stall_cnt !== 16'd0 || ia.flush_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL rst_wait_abort: got %b stall=%0d flush=%0d want 000000/0/0",
                     act_out(0), ia.stall_cnt, ia.flush_cnt);
        end
        tick();
        inp[0].mem_req = 1'b1;
        #4;
        n_cmp++;
        if (act_out(0) !== 6'b111000) begin
            n_err++;
            $display("FAIL rst_wait_restart: got %b want 111000", act_out(0));
        end
        tick();
        inp[0] = '0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_no_wait();
        inp[1] = '0;
        inp[1].mem_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #4;
            n_cmp++;
            if (act_out(1) !== 6'b000000) begin
                n_err++;
                $display("FAIL no_wait cyc%0d: got %b want 000000", k, act_out(1));
            end
            tick();
        end
        inp[1] = '0;
        #4;
        n_cmp++;
        if (ib.stall_cnt !== 4'd1) begin
            n_err++;
            $display("FAIL no_wait_cnt: got %0d want 1", ib.stall_cnt);
        end
        tick();
    endtask

    task automatic test_saturation();
        int want;
        inp[1] = '0;
        inp[1].src1 = 4'd5; inp[1].use1 = 1'b1; inp[1].exe_dest = 4'd5;
        inp[1].exe_wb = 1'b1; inp[1].exe_mr = 1'b1;
        for (int k = 0; k < 20; k++) begin
            want = (1 + k > 15) ? 15 : 1 + k;
            #4;
            n_cmp++;
            if (act_sc(1) !== want) begin
                n_err++;
                $display("FAIL sat_stall cyc%0d: got %0d want %0d", k, act_sc(1), want);
            end
            tick();
        end
        inp[1] = '0;
        inp[1].br = 1'b1;
        for (int k = 0; k < 20; k++) begin
            want = (k > 15) ? 15 : k;
            #4;
            n_cmp++;
            if (act_fc(1) !== want) begin
                n_err++;
                $display("FAIL sat_flush cyc%0d: got %0d want %0d", k, act_fc(1), want);
            end
            tick();
        end
        inp[1] = '0;
        #4;
        n_cmp++;
        if (ib.stall_cnt !== 4'hF || ib.flush_cnt !== 4'hF) begin
            n_err++;
            $display("FAIL sat_hold: got stall=%0d flush=%0d want 15/15", ib.stall_cnt, ib.flush_cnt);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            for (int d = 0; d < 2; d++) begin
                rstn[d] = ($urandom_range(0, 99) != 0);
                inp[d]  = rnd_in();
            end
            #4;
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (act_out(d) !== exp_out(d)) begin
                    n_err++;
                    $display("FAIL rand_out[%0d] cyc%0d: got %b want %b", d, c, act_out(d), exp_out(d));
                end
                n_cmp++;
                if (act_sc(d) !== sc[d] || act_fc(d) !== fc[d]) begin
                    n_err++;
                    $display("FAIL rand_cnt[%0d] cyc%0d: got %0d/%0d want %0d/%0d",
                             d, c, act_sc(d), act_fc(d), sc[d], fc[d]);
                end
            end
            tick();
        end
        inp[0]  = '0;
        inp[1]  = '0;
        rstn[0] = 1'b1;
        rstn[1] = 1'b1;
    endtask

    initial begin
        rstn[0] = 1'b0;
        rstn[1] = 1'b0;
        inp[0]  = '0;
        inp[1]  = '0;
        test_reset();
        test_mem_wait();
        test_back_to_back();
        test_hazard();
        test_branch_over_hazard();
        test_branch_in_wait();
        test_reset_in_wait();
        test_no_wait();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
